reg_rename_ctrl: RTL and testbench

Rename/commit controller for the architectural register file in the out-of-order RISC-V core. It owns the 32-entry value, busy and reorder-tag arrays. It records destination renames from ID, buffers and sequences ROB commits into register writes, and clears rename state on a ROB flush. Dispatch reads operands from it with a busy/tag indication.

---
 rtl/reg_rename_ctrl_pkg.sv | 38 +++
 rtl/reg_rename_ctrl_if.sv | 49 ++++
 rtl/reg_rename_ctrl_commit_fifo.sv | 56 +++++
 rtl/reg_rename_ctrl.sv | 150 +++++++++++++++
 tb/tb_reg_rename_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_rename_ctrl_pkg.sv
// Shared definitions for the register rename/commit controller: core-wide
// sizes, the Valid/Invalid/Null constants, FSM states and the record types
// that travel through the commit path.
package reg_rename_ctrl_pkg;

  localparam int REG_NUM     = 32;
  localparam int ADDR_W      = 5;
  localparam int TAG_W       = 4;
  localparam int DATA_W      = 32;
  localparam int CFIFO_DEPTH = 4;  // power of two, >= 2
  localparam int CFIFO_CNT_W = $clog2(CFIFO_DEPTH) + 1;

  localparam logic              VALID     = 1'b1;
  localparam logic              INVALID   = 1'b0;
  localparam logic [TAG_W-1:0]  NULL_TAG  = '0;
  localparam logic [DATA_W-1:0] NULL_DATA = '0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  // One buffered ROB commit.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } commit_t;

  // Result of one operand lookup.
  typedef struct packed {
    logic              busy;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } rd_t;

endpackage

// File: rtl/reg_rename_ctrl_if.sv
// Rename, operand-lookup and commit signals between ID/dispatch/ROB and the
// rename controller. slave = the controller, master = the pipeline side.
interface reg_rename_ctrl_if;
  import reg_rename_ctrl_pkg::*;

  logic              ID_reg_dest_valid;
  logic [ADDR_W-1:0] ID_reg_dest_addr;
  logic [TAG_W-1:0]  ID_reg_dest_reorder;
  logic [ADDR_W-1:0] ID_reg1_addr;
  logic [ADDR_W-1:0] ID_reg2_addr;
  logic              dispatch_reg1_busy;
  logic              dispatch_reg2_busy;
  logic [DATA_W-1:0] dispatch_reg1_data;
  logic [DATA_W-1:0] dispatch_reg2_data;
  logic [TAG_W-1:0]  dispatch_reg1_reorder;
  logic [TAG_W-1:0]  dispatch_reg2_reorder;
  logic              ROB_commit_valid;
  logic [ADDR_W-1:0] ROB_commit_addr;
  logic [TAG_W-1:0]  ROB_commit_reorder;
  logic [DATA_W-1:0] ROB_commit_data;
  logic              ROB_commit_ready;
  logic              ROB_flush;
  logic              ID_stall;

  modport slave (
    input  ID_reg_dest_valid, ID_reg_dest_addr, ID_reg_dest_reorder,
    input  ID_reg1_addr, ID_reg2_addr,
    output dispatch_reg1_busy, dispatch_reg2_busy,
    output dispatch_reg1_data, dispatch_reg2_data,
    output dispatch_reg1_reorder, dispatch_reg2_reorder,
    input  ROB_commit_valid, ROB_commit_addr, ROB_commit_reorder, ROB_commit_data,
    output ROB_commit_ready,
    input  ROB_flush,
    output ID_stall
  );

  modport master (
    output ID_reg_dest_valid, ID_reg_dest_addr, ID_reg_dest_reorder,
    output ID_reg1_addr, ID_reg2_addr,
    input  dispatch_reg1_busy, dispatch_reg2_busy,
    input  dispatch_reg1_data, dispatch_reg2_data,
    input  dispatch_reg1_reorder, dispatch_reg2_reorder,
    output ROB_commit_valid, ROB_commit_addr, ROB_commit_reorder, ROB_commit_data,
    input  ROB_commit_ready,
    output ROB_flush,
    input  ID_stall
  );

endinterface

// File: rtl/reg_rename_ctrl_commit_fifo.sv
// Commit FIFO: synchronous push/pop gated by a global enable, with count,
// full and empty. Pushes while full and pops while empty are dropped.
module reg_rename_ctrl_commit_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_en,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_din,
  output logic [WIDTH-1:0]       o_dout,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_en && i_push && !o_full;
  assign w_pop   = i_en && i_pop && !o_empty;
  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Entry storage.
  // NOTE: storage carries no reset; an entry is only read after its push
  // writes it, and the pointers/count below define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/reg_rename_ctrl.sv
// Rename/commit controller for the architectural register file. Holds the
// value, busy and reorder-tag arrays, records renames from ID, sequences
// buffered ROB commits into register writes and clears rename state on a
// ROB flush (RUN -> DRAIN -> CLEAR -> RUN).
// Optional: define RENAME_BYPASS_EN to forward the popping commit onto a
// matching busy operand read in the same cycle.
module reg_rename_ctrl
  import reg_rename_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  reg_rename_ctrl_if.slave  bus
);

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [DATA_W-1:0]      r_regs [REG_NUM];
  logic [TAG_W-1:0]       r_tags [REG_NUM];
  logic [REG_NUM-1:0]     r_busy;

  commit_t                w_push_ent;
  commit_t                w_head;
  logic [CFIFO_CNT_W-1:0] w_count;
  logic [CFIFO_CNT_W-1:0] w_count_nxt;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_accept;
  logic                   w_pop;
  logic                   w_rename;

  logic [ADDR_W-1:0]      w_rd_addr [2];
  logic [1:0]             w_byp;
  rd_t                    w_rd [2];

  assign bus.ROB_commit_ready = rst_n && rdy && (r_state == ST_RUN) && !w_full;
  assign bus.ID_stall         = (r_state != ST_RUN);

  assign w_accept    = bus.ROB_commit_valid && bus.ROB_commit_ready;
  assign w_pop       = rdy && !w_empty;
  assign w_rename    = rdy && (r_state == ST_RUN) && bus.ID_reg_dest_valid &&
                       (bus.ID_reg_dest_addr != '0);
  assign w_count_nxt = w_count + CFIFO_CNT_W'(w_accept) - CFIFO_CNT_W'(w_pop);
  assign w_push_ent  = '{addr: bus.ROB_commit_addr, tag: bus.ROB_commit_reorder,
                         data: bus.ROB_commit_data};

  reg_rename_ctrl_commit_fifo #(
    .WIDTH ($bits(commit_t)),
    .DEPTH (CFIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (rdy),
    .i_push  (w_accept),
    .i_pop   (w_pop),
    .i_din   (w_push_ent),
    .o_dout  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // Next state: a flush drains whatever is still buffered, then clears.
  // NOTE: every always_comb output is defaulted first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    if (rdy) begin
      case (r_state)
        ST_RUN:   if (bus.ROB_flush) w_state_nxt = (w_count_nxt != '0) ? ST_DRAIN : ST_CLEAR;
        ST_DRAIN: if (w_count_nxt == '0) w_state_nxt = ST_CLEAR;
        ST_CLEAR: w_state_nxt = ST_RUN;
        default:  w_state_nxt = ST_RUN;
      endcase
    end
  end

  // Register file and rename state. A same-cycle rename is written after the
  // commit pop so it overrides the busy clear and tag for that register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        r_regs[i] <= NULL_DATA;
        r_tags[i] <= NULL_TAG;
      end
    end else if (rdy) begin
      if (r_state == ST_CLEAR) begin
        r_busy <= '0;
        for (int i = 0; i < REG_NUM; i++) r_tags[i] <= NULL_TAG;
      end else begin
        if (w_pop && (w_head.addr != '0)) begin
          r_regs[w_head.addr] <= w_head.data;
          if (r_tags[w_head.addr] == w_head.tag) r_busy[w_head.addr] <= INVALID;
        end
        if (w_rename) begin
          r_busy[bus.ID_reg_dest_addr] <= VALID;
          r_tags[bus.ID_reg_dest_addr] <= bus.ID_reg_dest_reorder;
        end
      end
    end
  end

  assign w_rd_addr[0] = bus.ID_reg1_addr;
  assign w_rd_addr[1] = bus.ID_reg2_addr;

`ifdef RENAME_BYPASS_EN
  // Forward the popping commit when it resolves the register being read.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_byp[p] = w_pop && (w_head.addr == w_rd_addr[p]) &&
                 (w_head.tag == r_tags[w_rd_addr[p]]);
    end
  end
`else
  assign w_byp = '0;
`endif

  // Operand lookup: x0, then busy (tag), then committed value.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rd[p] = '0;
      if (w_rd_addr[p] != '0) begin
        if (r_busy[w_rd_addr[p]]) begin
          if (w_byp[p]) begin
            w_rd[p].data = w_head.data;
          end else begin
            w_rd[p].busy = VALID;
            w_rd[p].tag  = r_tags[w_rd_addr[p]];
          end
        end else begin
          w_rd[p].data = r_regs[w_rd_addr[p]];
        end
      end
    end
  end

  assign bus.dispatch_reg1_busy    = w_rd[0].busy;
  assign bus.dispatch_reg1_reorder = w_rd[0].tag;
  assign bus.dispatch_reg1_data    = w_rd[0].data;
  assign bus.dispatch_reg2_busy    = w_rd[1].busy;
  assign bus.dispatch_reg2_reorder = w_rd[1].tag;
  assign bus.dispatch_reg2_data    = w_rd[1].data;

endmodule

// File: tb/tb_reg_rename_ctrl.sv
// Self-checking bench for reg_rename_ctrl: a queue/array model of the
// rename and commit rules, compared every cycle, plus directed scenarios
// with literal expectations.
module tb_reg_rename_ctrl;
  import reg_rename_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rdy   = 1'b0;

  reg_rename_ctrl_if bus ();

  reg_rename_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rdy   (rdy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit [4:0]  a;
    bit [3:0]  t;
    bit [31:0] d;
  } ent_t;

  ent_t      m_q[$];
  bit [31:0] m_regs  [32];
  bit        m_known [32];
  bit        m_busy  [32];
  bit [3:0]  m_tag   [32];
  int        m_phase = 0;   // 0 = normal, 1 = draining, 2 = clearing
  bit        m_push;
  ent_t      m_e;

  function automatic bit m_ready();
    return rst_n && rdy && (m_phase == 0) && (m_q.size() < CFIFO_DEPTH);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      for (int i = 0; i < 32; i++) begin
        m_busy[i] = 1'b0; m_tag[i] = '0; m_regs[i] = '0; m_known[i] = (i == 0);
      end
      m_phase = 0;
    end else if (rdy) begin
      m_push = bus.ROB_commit_valid && m_ready();
      if (m_phase == 2) begin
        for (int i = 0; i < 32; i++) begin m_busy[i] = 1'b0; m_tag[i] = '0; end
        m_phase = 0;
      end else begin
        if (m_q.size() > 0) begin
          m_e = m_q.pop_front();
          if (m_e.a != 0) begin
            m_regs[m_e.a] = m_e.d;
            m_known[m_e.a] = 1'b1;
            if (m_tag[m_e.a] == m_e.t) m_busy[m_e.a] = 1'b0;
          end
          if (m_phase == 1 && m_q.size() == 0) m_phase = 2;
        end
        if (m_phase == 0 && bus.ID_reg_dest_valid && bus.ID_reg_dest_addr != 0) begin
          m_busy[bus.ID_reg_dest_addr] = 1'b1;
          m_tag[bus.ID_reg_dest_addr]  = bus.ID_reg_dest_reorder;
        end
        if (m_push)
          m_q.push_back('{a: bus.ROB_commit_addr, t: bus.ROB_commit_reorder, d: bus.ROB_commit_data});
        if (m_phase == 0 && bus.ROB_flush) m_phase = (m_q.size() != 0) ? 1 : 2;
      end
    end
  end

  bit        c_b;
  bit [3:0]  c_t;
  bit [31:0] c_d;
  bit        c_k;

  function automatic void m_read(input bit [4:0] a);
    c_b = 1'b0; c_t = '0; c_d = '0; c_k = 1'b1;
    if (a == 0) return;
    if (m_busy[a]) begin
`ifdef RENAME_BYPASS_EN
      if (rdy && m_q.size() > 0 && m_q[0].a == a && m_q[0].t == m_tag[a]) begin
        c_d = m_q[0].d;
        return;
      end
`endif
      c_b = 1'b1; c_t = m_tag[a];
      return;
    end
    c_d = m_regs[a];
    c_k = m_known[a];
  endfunction

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      m_read(bus.ID_reg1_addr);
      check("r1_busy", 32'(bus.dispatch_reg1_busy), 32'(c_b));
      check("r1_tag",  32'(bus.dispatch_reg1_reorder), 32'(c_t));
      if (c_k) check("r1_data", bus.dispatch_reg1_data, c_d);
      m_read(bus.ID_reg2_addr);
      check("r2_busy", 32'(bus.dispatch_reg2_busy), 32'(c_b));
      check("r2_tag",  32'(bus.dispatch_reg2_reorder), 32'(c_t));
      if (c_k) check("r2_data", bus.dispatch_reg2_data, c_d);
      check("ready", 32'(bus.ROB_commit_ready), 32'(m_ready()));
      check("stall", 32'(bus.ID_stall), 32'(m_phase != 0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ID_reg_dest_valid = 1'b0;
    bus.ROB_commit_valid  = 1'b0;
    bus.ROB_flush         = 1'b0;
  endtask

  task automatic rename(input bit [4:0] a, input bit [3:0] t);
    bus.ID_reg_dest_valid   = 1'b1;
    bus.ID_reg_dest_addr    = a;
    bus.ID_reg_dest_reorder = t;
  endtask

  task automatic commit(input bit [4:0] a, input bit [3:0] t, input bit [31:0] d);
    bus.ROB_commit_valid   = 1'b1;
    bus.ROB_commit_addr    = a;
    bus.ROB_commit_reorder = t;
    bus.ROB_commit_data    = d;
  endtask

  initial begin
    idle();
    bus.ID_reg_dest_addr = '0; bus.ID_reg_dest_reorder = '0;
    bus.ROB_commit_addr = '0; bus.ROB_commit_reorder = '0; bus.ROB_commit_data = '0;
    bus.ID_reg1_addr = 5'd3; bus.ID_reg2_addr = 5'd0;
    rdy = 1'b1;
    cmp_en = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst_ready", 32'(bus.ROB_commit_ready), 32'd0);
    check("rst_stall", 32'(bus.ID_stall), 32'd0);
    check("rst_busy",  32'(bus.dispatch_reg1_busy), 32'd0);
    check("rst_data",  bus.dispatch_reg1_data, 32'd0);
    step(); rst_n = 1'b1;
    step();

    // Rename x5 -> tag 3, visible next cycle; x0 always zero.
    rename(5'd5, 4'd3);
    step(); idle(); bus.ID_reg1_addr = 5'd5; bus.ID_reg2_addr = 5'd0;
    @(negedge clk);
    check("x5_busy", 32'(bus.dispatch_reg1_busy), 32'd1);
    check("x5_tag",  32'(bus.dispatch_reg1_reorder), 32'd3);
    check("x0_busy", 32'(bus.dispatch_reg2_busy), 32'd0);
    check("x0_data", bus.dispatch_reg2_data, 32'd0);

    // Commit x5 / tag 3 / 0xDEADBEEF into an empty FIFO.
    step(); commit(5'd5, 4'd3, 32'hDEAD_BEEF);
    @(negedge clk);
    check("commit_ready", 32'(bus.ROB_commit_ready), 32'd1);
    step(); idle();
    @(negedge clk);
`ifdef RENAME_BYPASS_EN
    check("pop_byp_busy", 32'(bus.dispatch_reg1_busy), 32'd0);
    check("pop_byp_data", bus.dispatch_reg1_data, 32'hDEAD_BEEF);
`else
    check("pop_busy", 32'(bus.dispatch_reg1_busy), 32'd1);
    check("pop_tag",  32'(bus.dispatch_reg1_reorder), 32'd3);
`endif
    step();
    @(negedge clk);
    check("after_pop_busy", 32'(bus.dispatch_reg1_busy), 32'd0);
    check("after_pop_data", bus.dispatch_reg1_data, 32'hDEAD_BEEF);

    // Stale commit: x7 renamed twice, commit of the older tag keeps busy.
    step(); rename(5'd7, 4'd1);
    step(); rename(5'd7, 4'd2);
    step(); idle(); commit(5'd7, 4'd1, 32'h0000_1234);
    step(); idle();
    step(); bus.ID_reg1_addr = 5'd7;
    @(negedge clk);
    check("x7_busy", 32'(bus.dispatch_reg1_busy), 32'd1);
    check("x7_tag",  32'(bus.dispatch_reg1_reorder), 32'd2);

    // Rename x1..x4, then flush together with an accepted commit.
    for (int i = 1; i <= 4; i++) begin
      step(); rename(5'(i), 4'(i));
    end
    step(); idle(); commit(5'd1, 4'd1, 32'h11); bus.ROB_flush = 1'b1;
    step(); idle();
    @(negedge clk);
    check("drain_stall", 32'(bus.ID_stall), 32'd1);
    check("drain_ready", 32'(bus.ROB_commit_ready), 32'd0);
    step();
    @(negedge clk);
    check("clear_stall", 32'(bus.ID_stall), 32'd1);
    step(); bus.ID_reg1_addr = 5'd1; bus.ID_reg2_addr = 5'd7;
    @(negedge clk);
    check("run_stall",  32'(bus.ID_stall), 32'd0);
    check("x1_busy",    32'(bus.dispatch_reg1_busy), 32'd0);
    check("x1_data",    bus.dispatch_reg1_data, 32'h11);
    check("x7_cleared", 32'(bus.dispatch_reg2_busy), 32'd0);
    check("x7_data",    bus.dispatch_reg2_data, 32'h0000_1234);

    // Reset asserted while draining.
    step(); rename(5'd2, 4'd5); commit(5'd3, 4'd6, 32'h33); bus.ROB_flush = 1'b1;
    bus.ID_reg1_addr = 5'd2;
    step(); idle();
    @(negedge clk);
    check("rdrain_stall", 32'(bus.ID_stall), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rreset_ready", 32'(bus.ROB_commit_ready), 32'd0);
    check("rreset_stall", 32'(bus.ID_stall), 32'd0);
    check("rreset_busy",  32'(bus.dispatch_reg1_busy), 32'd0);
    check("rreset_data",  bus.dispatch_reg1_data, 32'd0);
    step();
    @(negedge clk);
    check("rhold_ready", 32'(bus.ROB_commit_ready), 32'd0);
    step(); rst_n = 1'b1;
    @(negedge clk);
    check("rrel_ready", 32'(bus.ROB_commit_ready), 32'd1);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      bit [4:0] ca;
      step();
      rdy = ($urandom_range(0, 9) != 0);
      bus.ID_reg_dest_valid   = ($urandom_range(0, 1) == 1);
      bus.ID_reg_dest_addr    = 5'($urandom_range(0, 7));
      bus.ID_reg_dest_reorder = 4'($urandom);
      ca = 5'($urandom_range(0, 7));
      bus.ROB_commit_valid    = ($urandom_range(0, 1) == 1);
      bus.ROB_commit_addr     = ca;
      bus.ROB_commit_reorder  = ($urandom_range(0, 1) == 1) ? m_tag[ca] : 4'($urandom);
      bus.ROB_commit_data     = $urandom;
      bus.ROB_flush           = ($urandom_range(0, 24) == 0);
      bus.ID_reg1_addr        = 5'($urandom_range(0, 7));
      bus.ID_reg2_addr        = 5'($urandom_range(0, 7));
    end

    step(); idle(); rdy = 1'b1;
    step(); step();
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
